// File: rtl/mdu_ctrl_pkg.sv
// Shared MDU definitions: ALU op encodings, controller state encodings and helpers.
package mdu_ctrl_pkg;

  localparam logic [7:0]  EXE_MULT_OP    = 8'b0001_1000;
  localparam logic [7:0]  EXE_MULTU_OP   = 8'b0001_1001;
  localparam logic [7:0]  EXE_DIV_OP     = 8'b0001_1010;
  localparam logic [7:0]  EXE_DIVU_OP    = 8'b0001_1011;
  localparam logic [31:0] DIV_BY_ZERO_LO = 32'hFFFF_FFFF;

  typedef enum logic [1:0] {
    MDU_IDLE = 2'd0,
    MDU_MUL  = 2'd1,
    MDU_DIV  = 2'd2,
    MDU_DONE = 2'd3
  } mdu_state_e;

  // Magnitude of a 32-bit operand; unsigned operands pass through untouched.
  function automatic logic [31:0] mag32(input logic [31:0] v, input logic sgn);
    return (sgn && v[31]) ? (~v + 32'd1) : v;
  endfunction

endpackage

// File: rtl/mdu_ctrl_div_core.sv
// Restoring divider on operand magnitudes, one quotient bit per cycle.
// MDU_EARLY_OUT_EN: finish after one cycle when |dividend| < |divisor|.
module div_core
  import mdu_ctrl_pkg::*;
#(
  parameter int DIV_ITER = 32
) (
  input  logic        clk,
  input  logic        resetn,
  input  logic        start_i,
  input  logic        signed_i,
  input  logic [31:0] a_i,
  input  logic [31:0] b_i,
  output logic        done_o,
  output logic [31:0] quotient_o,
  output logic [31:0] remainder_o
);

  logic        run_q;
  logic [5:0]  cnt_q;
  logic [31:0] quo_q;
  logic [31:0] dvs_q;
  logic [32:0] rem_q;
  logic [32:0] trial;
  logic        early;

  assign trial = {rem_q[31:0], quo_q[31]} - {1'b0, dvs_q};

`ifdef MDU_EARLY_OUT_EN
  // Before the first iteration quo_q still holds the dividend magnitude.
  assign early = (cnt_q == 6'd0) && (quo_q < dvs_q);
`else
  assign early = 1'b0;
`endif

  assign done_o = run_q & ((dvs_q == 32'd0) | early | (cnt_q == 6'(DIV_ITER - 1)));

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      run_q <= 1'b0;
      cnt_q <= 6'd0;
    end else if (start_i) begin
      run_q <= 1'b1;
      cnt_q <= 6'd0;
    end else if (run_q) begin
      cnt_q <= cnt_q + 6'd1;
      if (done_o) run_q <= 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (start_i) begin
      quo_q <= mag32(a_i, signed_i);
      dvs_q <= mag32(b_i, signed_i);
      rem_q <= 33'd0;
    end else if (run_q) begin
      if (early) begin
        quo_q <= 32'd0;
        rem_q <= {1'b0, quo_q};
      end else if (!trial[32]) begin
        rem_q <= trial;
        quo_q <= {quo_q[30:0], 1'b1};
      end else begin
        rem_q <= {rem_q[31:0], quo_q[31]};
        quo_q <= {quo_q[30:0], 1'b0};
      end
    end
  end

  assign quotient_o  = quo_q;
  assign remainder_o = rem_q[31:0];

endmodule

// File: rtl/mdu_ctrl.sv
// EX-stage multiply/divide sequencer: stalls the pipe and issues one HI/LO write per op.
// MDU_EARLY_OUT_EN (in div_core) shortens divides with |dividend| < |divisor|.
module mdu_ctrl
  import mdu_ctrl_pkg::*;
#(
  parameter int MUL_LAT  = 2,
  parameter int DIV_ITER = 32
) (
  input  logic        clk,
  input  logic        resetn,
  input  logic        valid_e,
  input  logic [7:0]  alucontrol_e,
  input  logic [31:0] src_a,
  input  logic [31:0] src_b,
  input  logic        flush_e,
  output logic        stall_e,
  output logic        busy,
  output logic        hilo_we,
  output logic [31:0] hi_o,
  output logic [31:0] lo_o
);

  mdu_state_e  state_q, state_d;
  logic [2:0]  cnt_q;
  logic        div_op_q;
  logic        sgn_q;
  logic [31:0] a_q, b_q;
  logic [63:0] prod_q;
  logic [31:0] hi_q, lo_q;

  logic        is_mul, is_div, op_sgn, accept, stall_d, we_d, div_done;
  logic [31:0] div_quo, div_rem, res_hi, res_lo;
  logic [63:0] ext_a, ext_b;

  assign is_mul = (alucontrol_e == EXE_MULT_OP) || (alucontrol_e == EXE_MULTU_OP);
  assign is_div = (alucontrol_e == EXE_DIV_OP)  || (alucontrol_e == EXE_DIVU_OP);
  assign op_sgn = (alucontrol_e == EXE_MULT_OP) || (alucontrol_e == EXE_DIV_OP);
  assign accept = (state_q == MDU_IDLE) & valid_e & ~flush_e & (is_mul | is_div);

  // Sign-extending to 64 bits lets one unsigned multiplier serve MULT and MULTU.
  assign ext_a = op_sgn ? {{32{src_a[31]}}, src_a} : {32'd0, src_a};
  assign ext_b = op_sgn ? {{32{src_b[31]}}, src_b} : {32'd0, src_b};

  div_core #(.DIV_ITER(DIV_ITER)) u_div (
    .clk         (clk),
    .resetn      (resetn),
    .start_i     (accept & is_div),
    .signed_i    (op_sgn),
    .a_i         (src_a),
    .b_i         (src_b),
    .done_o      (div_done),
    .quotient_o  (div_quo),
    .remainder_o (div_rem)
  );

  always_comb begin
    state_d = state_q;
    stall_d = 1'b0;
    we_d    = 1'b0;
    case (state_q)
      MDU_IDLE: begin
        if (accept) begin
          stall_d = 1'b1;
          if (is_div)            state_d = MDU_DIV;
          else if (MUL_LAT == 1) state_d = MDU_DONE;
          else                   state_d = MDU_MUL;
        end
      end
      MDU_MUL: begin
        if (flush_e) state_d = MDU_IDLE;
        else begin
          stall_d = 1'b1;
          if (cnt_q == 3'(MUL_LAT - 1)) state_d = MDU_DONE;
        end
      end
      MDU_DIV: begin
        if (flush_e) state_d = MDU_IDLE;
        else begin
          stall_d = 1'b1;
          if (div_done) state_d = MDU_DONE;
        end
      end
      MDU_DONE: begin
        state_d = MDU_IDLE;
        we_d    = ~flush_e;
      end
      default: state_d = MDU_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q  <= MDU_IDLE;
      cnt_q    <= 3'd0;
      div_op_q <= 1'b0;
      hi_q     <= 32'd0;
      lo_q     <= 32'd0;
    end else begin
      state_q <= state_d;
      if (accept) begin
        cnt_q    <= 3'd1;
        div_op_q <= is_div;
      end else if (state_q == MDU_MUL) begin
        cnt_q <= cnt_q + 3'd1;
      end
      if (we_d) begin
        hi_q <= res_hi;
        lo_q <= res_lo;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (accept) begin
      a_q    <= src_a;
      b_q    <= src_b;
      sgn_q  <= op_sgn;
      prod_q <= ext_a * ext_b;
    end
  end

  // Quotient sign follows the operand sign mismatch; remainder follows the dividend.
  always_comb begin
    res_hi = prod_q[63:32];
    res_lo = prod_q[31:0];
    if (div_op_q) begin
      if (b_q == 32'd0) begin
        res_hi = a_q;
        res_lo = DIV_BY_ZERO_LO;
      end else begin
        res_lo = (sgn_q & (a_q[31] ^ b_q[31])) ? (~div_quo + 32'd1) : div_quo;
        res_hi = (sgn_q & a_q[31]) ? (~div_rem + 32'd1) : div_rem;
      end
    end
  end

  assign stall_e = resetn & stall_d;
  assign busy    = (state_q != MDU_IDLE);
  assign hilo_we = we_d;
  assign hi_o    = we_d ? res_hi : hi_q;
  assign lo_o    = we_d ? res_lo : lo_q;

endmodule

// File: tb/tb_mdu_ctrl.sv
// Self-checking bench for mdu_ctrl: directed and random ops against a timeline/arithmetic model.
module tb_mdu_ctrl;

  localparam int MUL_LAT = 2;
  localparam logic [7:0] OP_MULT  = 8'h18;
  localparam logic [7:0] OP_MULTU = 8'h19;
  localparam logic [7:0] OP_DIV   = 8'h1A;
  localparam logic [7:0] OP_DIVU  = 8'h1B;
  localparam logic [7:0] OP_ADD   = 8'h20;

  logic        clk = 1'b0;
  logic        resetn = 1'b0;
  logic        valid_e = 1'b0;
  logic        flush_e = 1'b0;
  logic [7:0]  alucontrol_e = 8'h00;
  logic [31:0] src_a = 32'd0;
  logic [31:0] src_b = 32'd0;
  logic        stall_e, busy, hilo_we;
  logic [31:0] hi_o, lo_o;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  mdu_ctrl #(.MUL_LAT(MUL_LAT), .DIV_ITER(32)) dut (
    .clk          (clk),
    .resetn       (resetn),
    .valid_e      (valid_e),
    .alucontrol_e (alucontrol_e),
    .src_a        (src_a),
    .src_b        (src_b),
    .flush_e      (flush_e),
    .stall_e      (stall_e),
    .busy         (busy),
    .hilo_we      (hilo_we),
    .hi_o         (hi_o),
    .lo_o         (lo_o)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  typedef struct {
    logic [31:0] hi;
    logic [31:0] lo;
    int          lat;
  } res_t;

  function automatic bit is_mdu(input logic [7:0] op);
    return (op == OP_MULT) || (op == OP_MULTU) || (op == OP_DIV) || (op == OP_DIVU);
  endfunction

  // Architectural result and accept-to-write latency of one op.
  function automatic res_t model_result(input logic [7:0] op, input logic [31:0] a, input logic [31:0] b);
    res_t   r;
    longint sa, sb, q, m;
    r.hi = 32'd0;
    r.lo = 32'd0;
    r.lat = 0;
    if (op == OP_MULT || op == OP_MULTU) begin
      sa = (op == OP_MULT) ? longint'($signed(a)) : longint'({32'd0, a});
      sb = (op == OP_MULT) ? longint'($signed(b)) : longint'({32'd0, b});
      q = sa * sb;
      r.hi = q[63:32];
      r.lo = q[31:0];
      r.lat = MUL_LAT;
    end else if (op == OP_DIV || op == OP_DIVU) begin
      if (b == 32'd0) begin
        r.hi = a;
        r.lo = 32'hFFFF_FFFF;
        r.lat = 2;
      end else begin
        sa = (op == OP_DIV) ? longint'($signed(a)) : longint'({32'd0, a});
        sb = (op == OP_DIV) ? longint'($signed(b)) : longint'({32'd0, b});
        q = sa / sb;
        m = sa % sb;
        r.lo = q[31:0];
        r.hi = m[31:0];
        r.lat = 33;
`ifdef MDU_EARLY_OUT_EN
        if (((sa < 0) ? -sa : sa) < ((sb < 0) ? -sb : sb)) r.lat = 2;
`endif
      end
    end
    return r;
  endfunction

  // Model: an op in flight with m_rem cycles left before its write cycle.
  bit          m_busy = 1'b0;
  int          m_rem = 0;
  logic [31:0] m_pend_hi = 32'd0, m_pend_lo = 32'd0;
  logic [31:0] m_last_hi = 32'd0, m_last_lo = 32'd0;
  res_t        mr;

  always_comb mr = model_result(alucontrol_e, src_a, src_b);

  function automatic bit m_accept();
    return resetn && !m_busy && valid_e && !flush_e && is_mdu(alucontrol_e);
  endfunction

  always @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      m_busy    <= 1'b0;
      m_rem     <= 0;
      m_last_hi <= 32'd0;
      m_last_lo <= 32'd0;
    end else if (m_busy) begin
      if (flush_e) m_busy <= 1'b0;
      else if (m_rem == 0) begin
        m_busy    <= 1'b0;
        m_last_hi <= m_pend_hi;
        m_last_lo <= m_pend_lo;
      end else m_rem <= m_rem - 1;
    end else if (m_accept()) begin
      m_busy    <= 1'b1;
      m_rem     <= mr.lat - 1;
      m_pend_hi <= mr.hi;
      m_pend_lo <= mr.lo;
    end
  end

  always @(negedge clk) begin
    bit acc, we;
    #2;
    acc = m_accept();
    we  = m_busy && (m_rem == 0) && !flush_e;
    chk("stall_e", 32'(stall_e), 32'(acc || (m_busy && (m_rem != 0) && !flush_e)));
    chk("busy", 32'(busy), 32'(m_busy));
    chk("hilo_we", 32'(hilo_we), 32'(we));
    chk("hi_o", hi_o, we ? m_pend_hi : m_last_hi);
    chk("lo_o", lo_o, we ? m_pend_lo : m_last_lo);
  end

  // Issue one op; with lit set, pin latency/results to the given hand-computed values.
  task automatic do_op(input logic [7:0] op, input logic [31:0] a, input logic [31:0] b,
                       input int flush_at, input bit lit,
                       input logic [31:0] eh, input logic [31:0] el, input int elat);
    int got;
    got = -1;
    @(negedge clk); #1;
    valid_e = 1'b1; alucontrol_e = op; src_a = a; src_b = b; flush_e = (flush_at == 0);
    #2;
    if (lit && flush_at != 0) chk("accept_stall", 32'(stall_e), 32'd1);
    if (!is_mdu(op)) begin
      @(negedge clk); #1;
      valid_e = 1'b0; flush_e = 1'b0;
      return;
    end
    for (int cyc = 1; cyc <= 40; cyc++) begin
      @(negedge clk); #1;
      valid_e = 1'b0; alucontrol_e = 8'($urandom); src_a = $urandom; src_b = $urandom;
      flush_e = (cyc == flush_at);
      #2;
      if (lit && cyc == flush_at) chk("flush_stall", 32'(stall_e), 32'd0);
      if (lit && flush_at >= 0 && cyc == flush_at + 1) chk("flush_idle", 32'(busy), 32'd0);
      if (lit && flush_at < 0 && cyc == elat - 1) chk("last_stall", 32'(stall_e), 32'd1);
      if (hilo_we) begin
        got = cyc;
        if (lit) begin
          chk("res_hi", hi_o, eh);
          chk("res_lo", lo_o, el);
        end
        break;
      end
      if (flush_at >= 0 && cyc > flush_at) break;
    end
    flush_e = 1'b0;
    if (lit) begin
      if (flush_at >= 0) chk("flushed_write", 32'(got), 32'hFFFF_FFFF);
      else               chk("latency", 32'(got), 32'(elat));
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, errors=%0d", errors);
    $fatal(1, "watchdog");
  end

  initial begin
    int er;
    res_t r;
    logic [7:0]  op;
    logic [31:0] a, b;
    int fl;

    er = 33;
`ifdef MDU_EARLY_OUT_EN
    er = 2;
`endif
    repeat (3) @(negedge clk);
    #1;
    chk("reset_busy", 32'(busy), 32'd0);
    chk("reset_hi", hi_o, 32'd0);
    @(negedge clk); #1 resetn = 1'b1;

    do_op(OP_MULT,  32'hFFFF_FFFD, 32'd7, -1, 1'b1, 32'hFFFF_FFFF, 32'hFFFF_FFEB, 2);
    do_op(OP_DIVU,  32'd100, 32'd7, -1, 1'b1, 32'd2, 32'd14, 33);
    do_op(OP_DIV,   32'hFFFF_FFF9, 32'd2, -1, 1'b1, 32'hFFFF_FFFF, 32'hFFFF_FFFD, 33);
    do_op(OP_DIV,   32'd5, 32'd0, -1, 1'b1, 32'd5, 32'hFFFF_FFFF, 2);
    do_op(OP_DIV,   32'd20, 32'd3, 10, 1'b1, 32'd0, 32'd0, 0);
    do_op(OP_MULTU, 32'hFFFF_FFFF, 32'd2, -1, 1'b1, 32'd1, 32'hFFFF_FFFE, 2);
    do_op(OP_DIV,   32'h8000_0000, 32'hFFFF_FFFF, -1, 1'b1, 32'd0, 32'h8000_0000, 33);
    do_op(OP_DIVU,  32'd3, 32'd10, -1, 1'b1, 32'd3, 32'd0, er);
    do_op(OP_DIV,   32'd20, 32'd3, 0, 1'b1, 32'd0, 32'd0, 0);
    do_op(OP_MULT,  32'd6, 32'd7, 2, 1'b1, 32'd0, 32'd0, 0);
    do_op(OP_ADD,   32'd1, 32'd2, -1, 1'b0, 32'd0, 32'd0, 0);

    // Reset in the middle of a divide.
    @(negedge clk); #1;
    valid_e = 1'b1; alucontrol_e = OP_DIV; src_a = 32'd1000; src_b = 32'd7; flush_e = 1'b0;
    for (int cyc = 1; cyc <= 15; cyc++) begin
      @(negedge clk); #1;
      valid_e = 1'b0;
      if (cyc == 15) resetn = 1'b0;
    end
    #2;
    chk("rst_stall", 32'(stall_e), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_we", 32'(hilo_we), 32'd0);
    chk("rst_hi", hi_o, 32'd0);
    chk("rst_lo", lo_o, 32'd0);
    @(negedge clk); #1;
    @(negedge clk); #1 resetn = 1'b1;
    do_op(OP_DIVU, 32'd9, 32'd3, -1, 1'b1, 32'd0, 32'd3, 33);

    for (int n = 0; n < 40; n++) begin
      case ($urandom_range(0, 4))
        0: op = OP_MULT;
        1: op = OP_MULTU;
        2: op = OP_DIV;
        3: op = OP_DIVU;
        default: op = OP_ADD;
      endcase
      case ($urandom_range(0, 5))
        0: begin a = $urandom; b = 32'd0; end
        1: begin a = 32'h8000_0000; b = 32'hFFFF_FFFF; end
        2: begin a = $urandom_range(0, 50); b = $urandom_range(51, 1000); end
        3: begin a = $urandom; b = $urandom_range(1, 7); if ($urandom_range(0, 1) == 1) b = ~b + 32'd1; end
        default: begin a = $urandom; b = $urandom; end
      endcase
      r = model_result(op, a, b);
      fl = ($urandom_range(0, 6) == 0) ? $urandom_range(0, (r.lat > 0) ? r.lat : 0) : -1;
      do_op(op, a, b, fl, 1'b0, 32'd0, 32'd0, 0);
    end

    repeat (3) @(negedge clk);
    #3;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
